cmp_arbiter: RTL and testbench

Priority arbiter that grants one of `N_REQ` requesters, each carrying a `PW`-bit priority. It shares a single magnitude comparator, scanning one requester per cycle. The block sits in front of a shared resource and holds the grant until the owner releases it. It sequences the team's g/e/l magnitude-compare datapath instead of replicating it `N_REQ` times.

---
 rtl/cmp_arb_pkg.sv | 18 +
 rtl/cmp_arbiter_cmp_mag.sv | 17 +
 rtl/cmp_arbiter.sv | 192 +++++++++++++++++++
 tb/tb_cmp_arbiter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/cmp_arb_pkg.sv
// Shared types and constants for cmp_arbiter: FSM state encoding, default
// parameter values and the scan-counter width helper.
package cmp_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    GRANT = 2'd2
  } state_t;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_PW    = 4;

  function automatic int scan_cnt_w(input int n_req);
    return (n_req <= 1) ? 1 : $clog2(n_req);
  endfunction

endpackage

// File: rtl/cmp_arbiter_cmp_mag.sv
// Combinational PW-bit magnitude comparator (a vs b) with g/e/l outputs;
// l is derived from g and e so exactly one output is always high.
module cmp_mag #(
  parameter int PW = 4
) (
  input  logic [PW-1:0] a,
  input  logic [PW-1:0] b,
  output logic          g,
  output logic          e,
  output logic          l
);

  assign g = (a > b);
  assign e = (a == b);
  assign l = ~g & ~e;

endmodule

// File: rtl/cmp_arbiter.sv
// Priority arbiter sequencing one shared cmp_mag over N_REQ snapshot entries.
// Define CMP_ARB_ROUND_ROBIN_EN to start each scan after the last winner.
// The owner-release input is named owner_release because release is a keyword.
module cmp_arbiter
  import cmp_arb_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int PW    = DEF_PW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req,
  input  logic [N_REQ*PW-1:0] prio,
  input  logic                owner_release,
  output logic [N_REQ-1:0]    grant,
  output logic                grant_valid,
  output logic [PW-1:0]       grant_prio,
  output logic                busy
);

  localparam int            CW       = scan_cnt_w(N_REQ);
  localparam logic [CW-1:0] LAST_IDX = CW'(N_REQ - 1);
  localparam logic [CW-1:0] IDX_ONE  = CW'(1);
  localparam logic [CW-1:0] IDX_ZERO = CW'(0);
  localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

  state_t              state_r, state_nxt_s;
  logic [N_REQ-1:0]    snap_req_r, snap_req_nxt_s;
  logic [N_REQ*PW-1:0] snap_prio_r, snap_prio_nxt_s;
  logic [CW-1:0]       pos_r, pos_nxt_s;
  logic [CW-1:0]       cnt_r, cnt_nxt_s;
  logic                done_r, done_nxt_s;
  logic                best_valid_r, best_valid_nxt_s;
  logic [CW-1:0]       best_idx_r, best_idx_nxt_s;
  logic [PW-1:0]       best_prio_r, best_prio_nxt_s;
  logic [N_REQ-1:0]    grant_r, grant_nxt_s;
  logic                grant_valid_r, grant_valid_nxt_s;
  logic [PW-1:0]       grant_prio_r, grant_prio_nxt_s;
  logic                busy_r, busy_nxt_s;

  logic [CW-1:0]       start_s;
  logic [PW-1:0]       cand_prio_s;
  logic                cand_req_s;
  logic                cmp_g_s, cmp_e_s, cmp_l_s;
  logic                take_s;

`ifdef CMP_ARB_ROUND_ROBIN_EN
  logic [CW-1:0] last_r;

  // Remember the most recent winner so the next scan begins just after it.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= LAST_IDX;
    end else if (state_r == SCAN && state_nxt_s == GRANT) begin
      last_r <= best_idx_r;
    end
  end

  assign start_s = (last_r == LAST_IDX) ? IDX_ZERO : last_r + IDX_ONE;
`else
  assign start_s = IDX_ZERO;
`endif

  assign cand_prio_s = snap_prio_r[pos_r*PW +: PW];
  assign cand_req_s  = snap_req_r[pos_r];

  cmp_mag #(.PW(PW)) u_cmp (
    .a (cand_prio_s),
    .b (best_prio_r),
    .g (cmp_g_s),
    .e (cmp_e_s),
    .l (cmp_l_s)
  );

  // Ties and smaller candidates keep the earlier-scanned best.
  assign take_s = cand_req_s & (~best_valid_r | (cmp_g_s & ~(cmp_e_s | cmp_l_s)));

  // Next-state and next-output logic for the IDLE/SCAN/GRANT sequencer.
  always_comb begin
    state_nxt_s       = state_r;
    snap_req_nxt_s    = snap_req_r;
    snap_prio_nxt_s   = snap_prio_r;
    pos_nxt_s         = pos_r;
    cnt_nxt_s         = cnt_r;
    done_nxt_s        = done_r;
    best_valid_nxt_s  = best_valid_r;
    best_idx_nxt_s    = best_idx_r;
    best_prio_nxt_s   = best_prio_r;
    grant_nxt_s       = grant_r;
    grant_valid_nxt_s = grant_valid_r;
    grant_prio_nxt_s  = grant_prio_r;
    busy_nxt_s        = busy_r;
    case (state_r)
      IDLE: begin
        if (|req) begin
          snap_req_nxt_s   = req;
          snap_prio_nxt_s  = prio;
          best_valid_nxt_s = 1'b0;
          pos_nxt_s        = start_s;
          cnt_nxt_s        = IDX_ZERO;
          done_nxt_s       = 1'b0;
          busy_nxt_s       = 1'b1;
          state_nxt_s      = SCAN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SCAN: begin
        if (done_r) begin
          if (best_valid_r) begin
            grant_nxt_s       = ONE_HOT0 << best_idx_r;
            grant_valid_nxt_s = 1'b1;
            grant_prio_nxt_s  = best_prio_r;
            state_nxt_s       = GRANT;
          end else begin
            busy_nxt_s  = 1'b0;
            state_nxt_s = IDLE;
          end
        end else begin
          if (take_s) begin
            best_valid_nxt_s = 1'b1;
            best_idx_nxt_s   = pos_r;
            best_prio_nxt_s  = cand_prio_s;
          end else begin
            best_valid_nxt_s = best_valid_r;
          end
          pos_nxt_s  = (pos_r == LAST_IDX) ? IDX_ZERO : pos_r + IDX_ONE;
          cnt_nxt_s  = cnt_r + IDX_ONE;
          done_nxt_s = (cnt_r == LAST_IDX);
        end
      end
      GRANT: begin
        // The owner is checked against the live request, not the snapshot.
        if (owner_release || !req[best_idx_r]) begin
          grant_nxt_s       = {N_REQ{1'b0}};
          grant_valid_nxt_s = 1'b0;
          grant_prio_nxt_s  = {PW{1'b0}};
          busy_nxt_s        = 1'b0;
          state_nxt_s       = IDLE;
        end else begin
          state_nxt_s = GRANT;
        end
      end
      default: begin
        grant_nxt_s       = {N_REQ{1'b0}};
        grant_valid_nxt_s = 1'b0;
        grant_prio_nxt_s  = {PW{1'b0}};
        busy_nxt_s        = 1'b0;
        state_nxt_s       = IDLE;
      end
    endcase
  end

  // State, snapshot, scan and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      snap_req_r    <= {N_REQ{1'b0}};
      snap_prio_r   <= {(N_REQ*PW){1'b0}};
      pos_r         <= IDX_ZERO;
      cnt_r         <= IDX_ZERO;
      done_r        <= 1'b0;
      best_valid_r  <= 1'b0;
      best_idx_r    <= IDX_ZERO;
      best_prio_r   <= {PW{1'b0}};
      grant_r       <= {N_REQ{1'b0}};
      grant_valid_r <= 1'b0;
      grant_prio_r  <= {PW{1'b0}};
      busy_r        <= 1'b0;
    end else begin
      state_r       <= state_nxt_s;
      snap_req_r    <= snap_req_nxt_s;
      snap_prio_r   <= snap_prio_nxt_s;
      pos_r         <= pos_nxt_s;
      cnt_r         <= cnt_nxt_s;
      done_r        <= done_nxt_s;
      best_valid_r  <= best_valid_nxt_s;
      best_idx_r    <= best_idx_nxt_s;
      best_prio_r   <= best_prio_nxt_s;
      grant_r       <= grant_nxt_s;
      grant_valid_r <= grant_valid_nxt_s;
      grant_prio_r  <= grant_prio_nxt_s;
      busy_r        <= busy_nxt_s;
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_prio  = grant_prio_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_cmp_arbiter.sv
// Scoreboard bench for cmp_arbiter (default build: scan from index 0).
// Stimulus pushes the expected grant, priority and arrival cycle; a monitor checks each new grant.
module tb_cmp_arbiter;

  localparam int N_REQ = 4;
  localparam int PW    = 4;

  typedef struct {
    logic [N_REQ-1:0] g;
    logic [PW-1:0]    p;
    int               cyc;
  } exp_t;

  logic                clk;
  logic                rst;
  logic [N_REQ-1:0]    req;
  logic [N_REQ*PW-1:0] prio;
  logic                owner_release;
  logic [N_REQ-1:0]    grant;
  logic                grant_valid;
  logic [PW-1:0]       grant_prio;
  logic                busy;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   gv_seen = 1'b0;
  exp_t sb_q[$];

  cmp_arbiter #(.N_REQ(N_REQ), .PW(PW)) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .prio          (prio),
    .owner_release (owner_release),
    .grant         (grant),
    .grant_valid   (grant_valid),
    .grant_prio    (grant_prio),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called right after the edge preceding the IDLE sampling edge t = cyc+1;
  // grant_valid must rise after edge t + N_REQ + 1.
  task automatic push_exp(input logic [N_REQ-1:0] g, input logic [PW-1:0] p);
    exp_t e;
    e.g   = g;
    e.p   = p;
    e.cyc = cyc + 1 + N_REQ + 1;
    sb_q.push_back(e);
  endtask

  // Monitor: each rising grant_valid is matched against the scoreboard head.
  always @(negedge clk) begin
    if (grant_valid && !gv_seen) begin
      gv_seen = 1'b1;
      if (sb_q.size() == 0) begin
        check("unexpected_grant", {28'd0, grant}, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("grant", {28'd0, grant}, {28'd0, e.g});
        check("grant_prio", {28'd0, grant_prio}, {28'd0, e.p});
        check("grant_latency", cyc, e.cyc);
      end
    end
    if (!grant_valid) gv_seen = 1'b0;
  end

  task automatic issue(input logic [N_REQ-1:0] r, input logic [N_REQ*PW-1:0] p);
    @(posedge clk); #1;
    req  = r;
    prio = p;
  endtask

  task automatic wait_grant(input string name);
    for (int i = 0; i < 20; i++) begin
      if (grant_valid) break;
      @(posedge clk); #1;
    end
    check(name, {31'd0, grant_valid}, 32'd1);
  endtask

  task automatic check_clear(input string name);
    check({name, "_gv"}, {31'd0, grant_valid}, 32'd0);
    check({name, "_grant"}, {28'd0, grant}, 32'd0);
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
  endtask

  // Pulse release for one edge r, then present next_req for the IDLE edge r+1.
  task automatic release_grant(input logic [N_REQ-1:0] next_req);
    @(posedge clk); #1;
    owner_release = 1'b1;
    @(posedge clk); #1;
    owner_release = 1'b0;
    req = next_req;
    check_clear("release");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    prio = {4'd1, 4'd1, 4'd1, 4'd1};
    owner_release = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_clear("reset");
    check("reset_gprio", {28'd0, grant_prio}, 32'd0);
    rst = 1'b0;
    push_exp(4'b0001, 4'd1);
    @(posedge clk); #1;
    check("busy_after_sample", {31'd0, busy}, 32'd1);
    wait_grant("grant_reset_exit");
    release_grant(4'b0000);

    // Entries 3..0 prio 5,9,3,7; entry 2 idle, so entry 0 (7) wins.
    issue(4'b1011, {4'd5, 4'd9, 4'd3, 4'd7});
    push_exp(4'b0001, 4'd7);
    wait_grant("grant_strict_a");
    release_grant(4'b0000);

    issue(4'b1010, {4'd5, 4'd9, 4'd3, 4'd7});
    push_exp(4'b1000, 4'd5);
    wait_grant("grant_strict_b");
    release_grant(4'b0000);

    // Tie between entries 1 and 2: lower index kept.
    issue(4'b0110, {4'd0, 4'd8, 4'd8, 4'd0});
    push_exp(4'b0010, 4'd8);
    wait_grant("grant_tie");
    release_grant(4'b0000);

    // Request rising mid-scan is ignored until the next snapshot.
    issue(4'b0001, {4'd0, 4'd0, 4'd0, 4'd2});
    push_exp(4'b0001, 4'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    req  = 4'b1001;
    prio = {4'd15, 4'd0, 4'd0, 4'd2};
    wait_grant("grant_midscan");
    release_grant(4'b1001);
    push_exp(4'b1000, 4'd15);
    wait_grant("grant_after_midscan");
    release_grant(4'b0000);

    // Owner drops its request without release.
    issue(4'b0100, {4'd0, 4'd6, 4'd0, 4'd0});
    push_exp(4'b0100, 4'd6);
    wait_grant("grant_owner");
    @(posedge clk); #1;
    req = 4'b0000;
    @(posedge clk); #1;
    check_clear("owner_drop");

    // Reset during scan discards it; re-arbitration follows.
    issue(4'b0010, {4'd0, 4'd0, 4'd4, 4'd0});
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    check_clear("rst_midscan");
    rst = 1'b0;
    push_exp(4'b0010, 4'd4);
    wait_grant("grant_after_rst");
    release_grant(4'b0000);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
